pc_sequencer: RTL and testbench

- Owns the program counter and decides the next PC each cycle: sequential PC+4, branch target, or jump target.
- Drives PcNext (PC+4) into the branch-target PcAdder and consumes the adder's AddAluOut as the taken-branch target.
- Issues the IF/ID flush and pipeline-hold sequencing for control hazards, and counts redirects.
- Sits between instruction memory, the hazard unit, and the ID/EX branch/jump resolution logic.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/pc_sequencer.sv | 73 +++++++
 tb/tb_pc_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_seq_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pcState_t;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  function automatic logic isMisaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program counter owner: sequential / branch / jump selection, IF/ID flush, redirect counting.
// Build option BRANCH_DELAY_SLOT_EN selects delay-slot semantics (no FLUSH state, Flush tied low).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Stall,
  input  logic                 Branch,
  input  logic                 Zero,
  input  logic                 Jump,
  input  logic [31:0]          JumpTarget,
  input  logic [31:0]          AddAluOut,
  output logic [31:0]          Pc,
  output logic [31:0]          PcNext,
  output logic                 Flush,
  output logic                 Redirect,
  output logic                 MisalignErr,
  output logic [CNT_WIDTH-1:0] RedirectCount
);

  logic        resolveEn;
  logic        doRedirect;
  logic [31:0] target;

`ifdef BRANCH_DELAY_SLOT_EN
  assign resolveEn = 1'b1;
  assign Flush     = 1'b0;
`else
  pcState_t state;
  // Branch/Jump seen while flushing belong to the killed instruction.
  assign resolveEn = (state == RUN);
  assign Flush     = (state == FLUSH);
`endif

  assign PcNext = Pc + PC_INCR;

  always_comb begin
    target     = Jump ? JumpTarget : AddAluOut;
    doRedirect = resolveEn & (Jump | (Branch & Zero));
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pc            <= RESET_PC;
      Redirect      <= 1'b0;
      MisalignErr   <= 1'b0;
      RedirectCount <= '0;
`ifndef BRANCH_DELAY_SLOT_EN
      state         <= RUN;
`endif
    end else begin
      Redirect <= doRedirect;
      if (doRedirect) begin
        Pc <= target & ALIGN_MASK;
        if (isMisaligned(target)) MisalignErr <= 1'b1;
        if (RedirectCount != '1) RedirectCount <= RedirectCount + CNT_WIDTH'(1);
`ifndef BRANCH_DELAY_SLOT_EN
        state <= FLUSH;
`endif
      end else if (!Stall) begin
        Pc <= PcNext;
`ifndef BRANCH_DELAY_SLOT_EN
        state <= RUN;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random traffic against a reference model.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Branch, Zero, Jump;
  logic [31:0] JumpTarget, AddAluOut;

  logic [31:0] pcA, pcNextA, pcB, pcNextB;
  logic        flushA, redirA, misA, flushB, redirB, misB;
  logic [3:0]  cntA;
  logic [15:0] cntB;

  always #5 Clk = ~Clk;

  // Small counter to reach saturation quickly.
  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(4)) dutA (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .JumpTarget(JumpTarget), .AddAluOut(AddAluOut),
    .Pc(pcA), .PcNext(pcNextA), .Flush(flushA), .Redirect(redirA),
    .MisalignErr(misA), .RedirectCount(cntA)
  );

  // Near-top reset address to exercise wrap-around.
  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dutB (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch), .Zero(Zero), .Jump(Jump),
    .JumpTarget(JumpTarget), .AddAluOut(AddAluOut),
    .Pc(pcB), .PcNext(pcNextB), .Flush(flushB), .Redirect(redirB),
    .MisalignErr(misB), .RedirectCount(cntB)
  );

  typedef struct {
    logic [31:0] pc;
    bit          flushing;
    bit          redir;
    bit          mis;
    int          cnt;
  } model_t;

  typedef struct {
    model_t a;
    model_t b;
  } exp_t;

  exp_t   sb[$];
  model_t mA, mB;
  int     nCmp = 0;
  int     nErr = 0;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif

  // Reference: what the next fetch address and status must be after one clock.
  function automatic model_t modelStep(model_t s, bit rst, bit stall, bit br, bit z, bit j,
                                       logic [31:0] jt, logic [31:0] aa,
                                       logic [31:0] rpc, int cmax);
    model_t n = s;
    bit          honoured;
    logic [31:0] tgt;
    if (rst) begin
      n.pc = rpc; n.flushing = 0; n.redir = 0; n.mis = 0; n.cnt = 0;
      return n;
    end
    honoured = DELAY_SLOT || !s.flushing;
    n.redir  = honoured && (j || (br && z));
    if (n.redir) begin
      tgt        = j ? jt : aa;
      n.pc       = {tgt[31:2], 2'b00};
      n.mis      = s.mis || (tgt % 4 != 0);
      n.cnt      = (s.cnt < cmax) ? s.cnt + 1 : cmax;
      n.flushing = !DELAY_SLOT;
    end else if (!stall) begin
      n.pc       = s.pc + 32'd4;
      n.flushing = 0;
    end
    return n;
  endfunction

  task automatic step(input bit rst, input bit stall, input bit br, input bit z, input bit j,
                      input logic [31:0] jt, input logic [31:0] aa);
    exp_t e;
    @(negedge Clk);
    Reset = rst; Stall = stall; Branch = br; Zero = z; Jump = j;
    JumpTarget = jt; AddAluOut = aa;
    mA = modelStep(mA, rst, stall, br, z, j, jt, aa, 32'h0000_0000, 15);
    mB = modelStep(mB, rst, stall, br, z, j, jt, aa, 32'hFFFF_FFF8, 65535);
    e.a = mA; e.b = mB;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pcA",      pcA,            e.a.pc);
        chk("pcNextA",  pcNextA,        e.a.pc + 32'd4);
        chk("flushA",   32'(flushA),    32'(e.a.flushing));
        chk("redirA",   32'(redirA),    32'(e.a.redir));
        chk("misA",     32'(misA),      32'(e.a.mis));
        chk("cntA",     32'(cntA),      e.a.cnt);
        chk("pcB",      pcB,            e.b.pc);
        chk("pcNextB",  pcNextB,        e.b.pc + 32'd4);
        chk("flushB",   32'(flushB),    32'(e.b.flushing));
        chk("cntB",     32'(cntB),      e.b.cnt);
        chk("misB",     32'(misB),      32'(e.b.mis));
      end
    end
  end

  initial begin : stimulus
    mA = '{pc: 32'h0, flushing: 0, redir: 0, mis: 0, cnt: 0};
    mB = mA;
    Reset = 1; Stall = 0; Branch = 0; Zero = 0; Jump = 0; JumpTarget = 0; AddAluOut = 0;

    // Reset, then sequential fetch; dutB wraps FFFF_FFF8 -> FFFF_FFFC -> 0.
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Taken branch at Pc=0x8 to 0x110, then one flush cycle to 0x114.
    step(0, 0, 1, 1, 0, 0, 32'h110);
    step(0, 0, 0, 0, 0, 0, 0);
    // Jump beats branch; jump during flush is ignored.
    step(0, 0, 1, 1, 1, 32'h400, 32'h200);
    step(0, 0, 0, 0, 1, 32'h800, 0);
    // Get to 0x20 and stall there.
    step(0, 0, 0, 0, 1, 32'h1C, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // Branch overrides stall; stall extends flush.
    step(0, 1, 1, 1, 0, 0, 32'h300);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 32'h900);
    step(0, 0, 0, 0, 0, 0, 0);
    // Branch not taken with Zero=0.
    step(0, 0, 1, 0, 0, 0, 32'h700);
    // Misaligned target, sticky error.
    step(0, 0, 1, 1, 0, 0, 32'h113);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Back-to-back branches (second honoured only in delay-slot build).
    step(0, 0, 1, 1, 0, 0, 32'h110);
    step(0, 0, 1, 1, 0, 0, 32'h220);
    step(0, 0, 0, 0, 0, 0, 0);
    // Reset during flush.
    step(0, 0, 0, 0, 1, 32'h500, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Many redirects to drive the narrow counter into saturation.
    for (int i = 0; i < 40; i++) step(0, 0, 0, 0, (i % 2) == 0, 32'h40 * i, 0);

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
           $urandom_range(1) == 1, $urandom_range(5) == 0,
           ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'h0000_FFFC),
           ($urandom_range(7) == 0) ? $urandom : ($urandom & 32'h0000_FFFC));
    end

    @(negedge Clk);
    @(negedge Clk);
    chk("scoreboardDrained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
